run_length_fsm: RTL and testbench
=================================

RUN_LENGTH_FSM -- requirements
Module: run_length_fsm

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8: width of the run-length and cycle-count values; legal values 2..16.
REQ-002 SHALL have port i_clock, input, 1: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port i_reset_async, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port i_isRun, input, 1: start request; sampled only in IDLE.
REQ-005 SHALL have port i_num_cnt, input, CNT_WIDTH: run length N in cycles; latched at the start.
REQ-006 SHALL have port i_abort, input, 1: abort request; honoured only in RUN and only when the abort feature is compiled in.
REQ-007 SHALL have port o_idle, output, 1: high while the state is IDLE.
REQ-008 SHALL have port o_running, output, 1: high while the state is RUN.
REQ-009 SHALL have port o_done, output, 1: one-cycle completion pulse, high while the state is DONE.
REQ-010 SHALL have port o_cnt, output, CNT_WIDTH: elapsed RUN cycles; 0 outside RUN.

Function
REQ-011 SHALL implement three states, IDLE=2'b00, RUN=2'b01 and DONE=2'b10, held in a 2-bit state register.
REQ-012 SHALL decode o_idle, o_running and o_done from the state register only (Moore outputs), with no combinational path from any input.
REQ-013 SHALL, in IDLE with i_isRun=1 and i_num_cnt!=0, latch i_num_cnt, clear the counter and enter RUN on the next edge.
REQ-014 SHALL, in IDLE with i_isRun=1 and i_num_cnt==0, enter DONE directly on the next edge (zero-length run).
REQ-015 SHALL, in IDLE with i_isRun=0, stay in IDLE.
REQ-016 SHALL increment o_cnt by 1 per cycle in RUN, presenting 0..N-1 across the N RUN cycles.
REQ-017 SHALL leave RUN for DONE on the edge at which o_cnt==N-1, so RUN lasts exactly N cycles.
REQ-018 SHALL keep latency fixed: i_isRun sampled high in cycle k gives RUN in k+1..k+N, o_done=1 in k+N+1, and IDLE in k+N+2.
REQ-019 SHALL remain in DONE for exactly one cycle and then return to IDLE unconditionally.
REQ-020 SHALL ignore i_isRun and i_num_cnt outside IDLE; changing i_num_cnt mid-run has no effect.
REQ-021 SHALL accept a new start in the first IDLE cycle after DONE (back-to-back runs).
REQ-022 SHALL support a maximum N of 2^CNT_WIDTH-1 with no counter wrap-around.
REQ-023 SHALL treat the unused encoding 2'b11 as illegal, drive all status outputs low while in it, and return to IDLE on the next edge.
REQ-024 SHALL give priority to abort when the last RUN cycle coincides with abort: the next state is IDLE and o_done stays low.

Reset
REQ-025 SHALL, while i_reset_async=1, immediately force state to IDLE, o_cnt and the latched N to 0, o_idle=1, o_running=0 and o_done=0.
REQ-026 SHALL, if reset is asserted mid-RUN or in DONE, discard the run with no o_done pulse after release.
REQ-027 SHALL take its first transition on the first rising edge after reset deassertion.

Configuration
REQ-028 SHALL compile the abort feature in when macro RUN_LENGTH_FSM_ABORT_EN is defined: in RUN, i_abort=1 moves the state to IDLE on the next edge, clears o_cnt and produces no o_done.
REQ-029 SHALL, when RUN_LENGTH_FSM_ABORT_EN is undefined, still have port i_abort but leave it unconnected internally, with every run completing normally.

Structure
REQ-030 SHALL take the state encodings (IDLE, RUN, DONE) and the state width from shared package fsm_pkg.
REQ-031 SHALL instantiate one sub-module, run_counter, parameterised by CNT_WIDTH, with clear, enable and terminal-count (count==N-1) ports.

Verification
REQ-032 SHALL cover: reset then i_isRun=1, i_num_cnt=5 -> o_running high 5 cycles with o_cnt 0..4, then o_done high exactly 1 cycle, then o_idle=1.
REQ-033 SHALL cover: i_isRun=1, i_num_cnt=0 -> o_done high in the next cycle, with o_running never asserted.
REQ-034 SHALL cover: CNT_WIDTH=4, i_num_cnt=15 -> exactly 15 RUN cycles with no wrap and o_cnt max 14; then i_isRun held high -> a new RUN starts in the cycle after the IDLE following DONE.
REQ-035 SHALL cover: with ABORT_EN defined, N=8 and i_abort=1 at o_cnt=3 -> IDLE next cycle with no o_done; without ABORT_EN -> i_abort is ignored and o_done occurs on schedule.
REQ-036 SHALL cover: i_reset_async pulsed at o_cnt=2 of an N=6 run -> outputs return to reset values immediately and there is no o_done.
REQ-037 SHALL cover: i_num_cnt changed 6->2 during RUN -> the run still lasts 6 cycles.

Source files
------------

// File: rtl/fsm_pkg.sv
// fsm_pkg: state encodings and state width shared by the run-length FSM
package fsm_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;
endpackage

// File: rtl/run_counter.sv
// run_counter: latches run length N on clear, counts up while enabled, flags count==N-1
// Ports: i_clock, i_reset_async (async active-high), clr (latch num, zero count),
//        en (increment), num (run length), cnt (elapsed count), tc (cnt==N-1)
module run_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset_async,
  input  logic                 clr,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] num,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 tc
);
  logic [CNT_WIDTH-1:0] n_q;
  always_ff @(posedge i_clock or posedge i_reset_async)
    if (i_reset_async) begin
      n_q <= '0;
      cnt <= '0;
    end else if (clr) begin
      n_q <= num;
      cnt <= '0;
    end else if (en)
      cnt <= cnt + 1'b1;
  // cnt stops at N-1 inside a run, so N up to 2^CNT_WIDTH-1 never wraps
  assign tc = cnt == n_q - 1'b1;
endmodule

// File: rtl/run_length_fsm.sv
// run_length_fsm: IDLE -> RUN for N cycles -> one-cycle DONE -> IDLE
// Ports: i_clock, i_reset_async (async active-high), i_isRun (start, IDLE only),
//        i_num_cnt (run length N), i_abort (RUN only, with RUN_LENGTH_FSM_ABORT_EN),
//        o_idle / o_running / o_done (Moore status), o_cnt (elapsed RUN cycles, 0 elsewhere)
// Build option: define RUN_LENGTH_FSM_ABORT_EN to honour i_abort; otherwise it is ignored.
module run_length_fsm
  import fsm_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clock,
  input  logic                 i_reset_async,
  input  logic                 i_isRun,
  input  logic [CNT_WIDTH-1:0] i_num_cnt,
  input  logic                 i_abort,
  output logic                 o_idle,
  output logic                 o_running,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_cnt
);
  state_t state, state_nxt;
  logic abort, start, tc;
  logic [CNT_WIDTH-1:0] cnt;
`ifdef RUN_LENGTH_FSM_ABORT_EN
  assign abort = i_abort;
`else
  logic unused_abort;
  assign unused_abort = i_abort;
  assign abort = 1'b0;
`endif
  assign start = state == IDLE && i_isRun && |i_num_cnt;
  run_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .i_clock      (i_clock),
    .i_reset_async(i_reset_async),
    .clr          (start),
    .en           (state == RUN),
    .num          (i_num_cnt),
    .cnt          (cnt),
    .tc           (tc)
  );
  always_ff @(posedge i_clock or posedge i_reset_async)
    if (i_reset_async) state <= IDLE;
    else state <= state_nxt;
  // abort outranks terminal count; DONE and the illegal code both fall back to IDLE
  always_comb begin
    state_nxt = IDLE;
    if (state == IDLE) begin
      if (i_isRun) state_nxt = |i_num_cnt ? RUN : DONE;
    end else if (state == RUN) begin
      if (!abort) state_nxt = tc ? DONE : RUN;
    end
  end
  assign o_idle    = state == IDLE;
  assign o_running = state == RUN;
  assign o_done    = state == DONE;
  assign o_cnt     = o_running ? cnt : '0;
endmodule

// File: tb/tb_run_length_fsm.sv
// tb_run_length_fsm: random and directed runs checked by a queue scoreboard against a run-schedule model
module tb_run_length_fsm;
  localparam int W = 4;
  typedef struct packed {
    logic idle;
    logic running;
    logic done;
    logic [W-1:0] cnt;
  } obs_t;
  logic clk = 0, rst = 1, is_run = 0, abort = 0;
  logic [W-1:0] num = '0;
  logic o_idle, o_running, o_done;
  logic [W-1:0] o_cnt;
  obs_t q[$];
  int errors = 0, checks = 0, runs = 0;
  bit armed = 0;
  run_length_fsm #(.CNT_WIDTH(W)) dut (
    .i_clock      (clk),
    .i_reset_async(rst),
    .i_isRun      (is_run),
    .i_num_cnt    (num),
    .i_abort      (abort),
    .o_idle       (o_idle),
    .o_running    (o_running),
    .o_done       (o_done),
    .o_cnt        (o_cnt)
  );
  always #5 clk = ~clk;
  function automatic obs_t mk(input logic i, r, d, input logic [W-1:0] c);
    obs_t o;
    o.idle = i; o.running = r; o.done = d; o.cnt = c;
    return o;
  endfunction
  task automatic cmp(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got idle=%b run=%b done=%b cnt=%0d, expected idle=%b run=%b done=%b cnt=%0d",
               name, act.idle, act.running, act.done, act.cnt, exp.idle, exp.running, exp.done, exp.cnt);
    end
  endtask
  always @(negedge clk)
    if (armed) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty: got no expectation at %0t, required one", $time);
      end else cmp("cycle", mk(o_idle, o_running, o_done, o_cnt), q.pop_front());
    end
  // Called at posedge+2 with q[0] describing the current cycle; schedules what follows the next edge.
  task automatic step(input logic r, input logic [W-1:0] n, input logic a);
    obs_t cur;
    is_run = r; num = n; abort = a;
    cur = q[0];
`ifdef RUN_LENGTH_FSM_ABORT_EN
    if (a && cur.running) begin
      q = {cur};
      q.push_back(mk(1, 0, 0, 0));
    end else
`endif
    if (q.size() == 1) begin
      if (cur.idle && r) begin
        runs++;
        for (int i = 0; i < int'(n); i++) q.push_back(mk(0, 1, 0, W'(i)));
        q.push_back(mk(0, 0, 1, 0));
      end else q.push_back(mk(1, 0, 0, 0));
    end
    @(posedge clk); #2;
  endtask
  task automatic do_reset();
    rst = 1;
    q.delete();
    q.push_back(mk(1, 0, 0, 0));
    #1 cmp("reset_immediate", mk(o_idle, o_running, o_done, o_cnt), mk(1, 0, 0, 0));
    @(posedge clk); #2;
    rst = 0;
    q.push_back(mk(1, 0, 0, 0));
  endtask
  initial begin
    @(posedge clk); #2;
    armed = 1;
    do_reset();
    step(1, 5, 0);
    repeat (8) step(0, 5, 0);
    step(1, 0, 0);
    repeat (3) step(0, 0, 1);
    repeat (40) step(1, 15, 0);
    repeat (20) step(0, 15, 0);
    step(1, 8, 0);
    for (int g = 0; g < 30 && !(q[0].running && q[0].cnt == 3); g++) step(0, 8, 0);
    repeat (12) step(0, 8, 1);
    step(1, 6, 0);
    for (int g = 0; g < 30 && !(q[0].running && q[0].cnt == 2); g++) step(0, 6, 0);
    do_reset();
    repeat (10) step(0, 6, 0);
    step(1, 6, 0);
    repeat (10) step(0, 2, 0);
    repeat (1500) step($urandom_range(0, 2) == 0,
                       ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1) * 15) : W'($urandom_range(0, 15)),
                       $urandom_range(0, 9) == 0);
    for (int g = 0; g < 40 && q.size() > 1; g++) step(0, 0, 0);
    if (q.size() > 1) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending expectations, required 1", q.size());
    end
    if (runs < 20) begin
      checks++; errors++;
      $display("FAIL run_count: got %0d started runs, required at least 20", runs);
    end
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
